// File: rtl/instr_fetch_if.sv
// Fetch-unit bus bundle: memory read port, instruction output port and redirect.
// The fetch unit is the slave; the core/memory environment is the master.
interface instr_fetch_if;
    logic        fetch_en;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic [15:0] instr_out;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;

    modport master (
        output fetch_en,
        output mem_rdata,
        output instr_ready,
        output redirect,
        output redirect_pc,
        input  mem_rd_en,
        input  mem_addr,
        input  instr_valid,
        input  instr_out,
        input  instr_pc
    );

    modport slave (
        input  fetch_en,
        input  mem_rdata,
        input  instr_ready,
        input  redirect,
        input  redirect_pc,
        output mem_rd_en,
        output mem_addr,
        output instr_valid,
        output instr_out,
        output instr_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: fetch PC, one-deep read tracking and a head-registered FIFO.
// Define INSTR_FETCH_PREFETCH_EN for a 2-entry prefetch buffer (default: 1 entry).
module instr_fetch (
    input  logic         clk,
    input  logic         reset,
    instr_fetch_if.slave bus
);

`ifdef INSTR_FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int FW = DEPTH * 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_r;
    logic [15:0]   pc_r;
    logic [15:0]   rd_pc_r;
    logic          inflight_r;
    logic [1:0]    count_r;
    logic [FW-1:0] fifo_r;

    logic          pop_s;
    logic          capture_s;
    logic          issue_s;
    logic [2:0]    occupancy_s;
    logic [FW-1:0] popped_fifo_s;
    logic [1:0]    popped_cnt_s;
    logic [FW-1:0] entry_s;
    logic [FW-1:0] fifo_nxt_s;
    logic [1:0]    count_nxt_s;

    // Entries are {instr, pc}, head in the low 32 bits; unused slots are kept at zero.
    assign pop_s       = (count_r != 2'd0) & bus.instr_ready & ~bus.redirect;
    assign capture_s   = inflight_r & ~bus.redirect;
    assign occupancy_s = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign issue_s     = ~reset & (state_r == RUN) & bus.fetch_en & ~bus.redirect
                         & (occupancy_s < 3'(DEPTH));

    assign popped_fifo_s = pop_s ? (fifo_r >> 6'd32) : fifo_r;
    assign popped_cnt_s  = pop_s ? (count_r - 2'd1) : count_r;
    assign entry_s       = capture_s ? (FW'({bus.mem_rdata, rd_pc_r}) << {popped_cnt_s[0], 5'b00000})
                                     : {FW{1'b0}};

    // FIFO next state; a redirect drops buffered entries and the data landing this cycle.
    always_comb begin
        fifo_nxt_s  = popped_fifo_s | entry_s;
        count_nxt_s = popped_cnt_s + {1'b0, capture_s};
        if (bus.redirect) begin
            fifo_nxt_s  = {FW{1'b0}};
            count_nxt_s = 2'd0;
        end else begin
            fifo_nxt_s  = popped_fifo_s | entry_s;
            count_nxt_s = popped_cnt_s + {1'b0, capture_s};
        end
    end

    // Control FSM: RUN while fetching is enabled; redirect does not affect state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.fetch_en) state_r <= RUN;
                    else              state_r <= IDLE;
                end
                RUN: begin
                    if (!bus.fetch_en) state_r <= IDLE;
                    else               state_r <= RUN;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Datapath registers: PC, outstanding-read tracking and FIFO contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r       <= 16'h0000;
            rd_pc_r    <= 16'h0000;
            inflight_r <= 1'b0;
            count_r    <= 2'd0;
            fifo_r     <= {FW{1'b0}};
        end else begin
            inflight_r <= issue_s;
            count_r    <= count_nxt_s;
            fifo_r     <= fifo_nxt_s;
            if (bus.redirect) begin
                pc_r <= bus.redirect_pc;
            end else if (issue_s) begin
                pc_r <= pc_r + 16'd1;
            end else begin
                pc_r <= pc_r;
            end
            if (issue_s) begin
                rd_pc_r <= pc_r;
            end else begin
                rd_pc_r <= rd_pc_r;
            end
        end
    end

    assign bus.mem_rd_en   = issue_s;
    assign bus.mem_addr    = issue_s ? pc_r : 16'h0000;
    assign bus.instr_valid = (count_r != 2'd0);
    assign bus.instr_out   = fifo_r[31:16];
    assign bus.instr_pc    = fifo_r[15:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; expectations follow INSTR_FETCH_PREFETCH_EN.
module tb_instr_fetch;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic        s_valid;
    logic        s_rd;
    logic [15:0] s_out;
    logic [15:0] s_pc;
    logic [15:0] s_addr;

`ifdef INSTR_FETCH_PREFETCH_EN
    localparam int STALL_ISSUES = 2;
`else
    localparam int STALL_ISSUES = 1;
`endif

    instr_fetch_if bus();

    instr_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: mem_word = 16'h1111;
            16'h0001: mem_word = 16'h2222;
            16'h0002: mem_word = 16'h3333;
            16'h0003: mem_word = 16'h4444;
            default:  mem_word = a ^ 16'h5A5A;
        endcase
    endfunction

    // Memory model: data one cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        bus.mem_rdata <= bus.mem_rd_en ? mem_word(bus.mem_addr) : 16'hDEAD;
    end

    task automatic cyc();
        @(negedge clk);
        s_valid = bus.instr_valid;
        s_rd    = bus.mem_rd_en;
        s_out   = bus.instr_out;
        s_pc    = bus.instr_pc;
        s_addr  = bus.mem_addr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.fetch_en = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 16'h0000;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.fetch_en = 1'b1;
        bus.instr_ready = 1'b1;
        bus.redirect = 1'b0;
        bus.redirect_pc = 16'h0000;
        cyc();
        cyc();
        checks++;
        if ({s_valid, s_rd, s_addr, s_out, s_pc} !== 50'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b rd=%0b addr=%h out=%h pc=%h, want all zero",
                     s_valid, s_rd, s_addr, s_out, s_pc);
        end
        reset = 1'b0;
    endtask

    task automatic test_stream();
        logic        e_rd;
        logic        e_valid;
        logic [15:0] e_addr;
        logic [15:0] e_pc;
        logic [15:0] e_out;
        do_reset();
        bus.fetch_en = 1'b1;
        bus.instr_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            cyc();
`ifdef INSTR_FETCH_PREFETCH_EN
            e_rd    = (c >= 1);
            e_addr  = e_rd ? 16'(c - 1) : 16'h0000;
            e_valid = (c >= 3);
            e_pc    = e_valid ? 16'(c - 3) : 16'h0000;
`else
            e_rd    = (c % 2 == 1);
            e_addr  = e_rd ? 16'((c - 1) / 2) : 16'h0000;
            e_valid = (c >= 3) && (c % 2 == 1);
            e_pc    = e_valid ? 16'((c - 3) / 2) : 16'h0000;
`endif
            e_out = e_valid ? mem_word(e_pc) : 16'h0000;
            checks++;
            if ({s_rd, s_addr, s_valid, s_pc, s_out} !== {e_rd, e_addr, e_valid, e_pc, e_out}) begin
                errors++;
                $display("FAIL stream c%0d: got rd=%0b addr=%h valid=%0b pc=%h out=%h, want rd=%0b addr=%h valid=%0b pc=%h out=%h",
                         c, s_rd, s_addr, s_valid, s_pc, s_out, e_rd, e_addr, e_valid, e_pc, e_out);
            end
        end
    endtask

    task automatic test_stall();
        int          n_iss;
        int          n_full_rd;
        logic        e_valid;
        logic [15:0] e_pc;
        logic [15:0] e_out;
        do_reset();
        bus.fetch_en = 1'b1;
        bus.instr_ready = 1'b0;
        n_iss = 0;
        n_full_rd = 0;
        for (int c = 0; c < 13; c++) begin
            cyc();
            if (s_rd) n_iss++;
            if (s_rd && c >= 3) n_full_rd++;
        end
        checks++;
        if (n_iss !== STALL_ISSUES) begin
            errors++;
            $display("FAIL stall_issues: got %0d, want %0d", n_iss, STALL_ISSUES);
        end
        checks++;
        if (n_full_rd !== 0) begin
            errors++;
            $display("FAIL stall_rd_while_full: got %0d strobes, want 0", n_full_rd);
        end
        checks++;
        if ({s_valid, s_pc, s_out} !== {1'b1, 16'h0000, 16'h1111}) begin
            errors++;
            $display("FAIL stall_head: got valid=%0b pc=%h out=%h, want 1 0000 1111", s_valid, s_pc, s_out);
        end
        bus.instr_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            cyc();
`ifdef INSTR_FETCH_PREFETCH_EN
            e_valid = 1'b1;
            e_pc    = 16'(r);
`else
            e_valid = (r % 2 == 0);
            e_pc    = e_valid ? 16'(r / 2) : 16'h0000;
`endif
            e_out = e_valid ? mem_word(e_pc) : 16'h0000;
            checks++;
            if ({s_valid, s_pc, s_out} !== {e_valid, e_pc, e_out}) begin
                errors++;
                $display("FAIL stall_drain r%0d: got valid=%0b pc=%h out=%h, want valid=%0b pc=%h out=%h",
                         r, s_valid, s_pc, s_out, e_valid, e_pc, e_out);
            end
        end
    endtask

    task automatic test_redirect();
        logic found;
        do_reset();
        bus.fetch_en = 1'b1;
        bus.instr_ready = 1'b1;
        repeat (6) cyc();
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'h0040;
        cyc();
        checks++;
        if (s_rd !== 1'b0) begin
            errors++;
            $display("FAIL redirect_no_issue: got rd=%0b, want 0", s_rd);
        end
        bus.redirect = 1'b0;
        cyc();
        checks++;
        if ({s_valid, s_rd, s_addr} !== {1'b0, 1'b1, 16'h0040}) begin
            errors++;
            $display("FAIL redirect_flush: got valid=%0b rd=%0b addr=%h, want 0 1 0040", s_valid, s_rd, s_addr);
        end
        cyc();
        checks++;
        if (s_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_stale: got valid=%0b pc=%h, want valid 0", s_valid, s_pc);
        end
        cyc();
        checks++;
        if ({s_valid, s_pc, s_out} !== {1'b1, 16'h0040, 16'h5A1A}) begin
            errors++;
            $display("FAIL redirect_first: got valid=%0b pc=%h out=%h, want 1 0040 5a1a", s_valid, s_pc, s_out);
        end
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (s_valid && !found) begin
                found = 1'b1;
                checks++;
                if ({s_pc, s_out} !== {16'h0041, 16'h5A1B}) begin
                    errors++;
                    $display("FAIL redirect_second: got pc=%h out=%h, want 0041 5a1b", s_pc, s_out);
                end
            end
        end
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL redirect_second_timeout: got no valid in 4 cycles, want pc 0041");
        end
    endtask

    task automatic test_wrap();
        int          n;
        logic [15:0] e_pc;
        bus.fetch_en = 1'b1;
        bus.instr_ready = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'hFFFF;
        cyc();
        bus.redirect = 1'b0;
        n = 0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            if (s_valid && n < 2) begin
                e_pc = (n == 0) ? 16'hFFFF : 16'h0000;
                checks++;
                if ({s_pc, s_out} !== {e_pc, mem_word(e_pc)}) begin
                    errors++;
                    $display("FAIL wrap_%0d: got pc=%h out=%h, want pc=%h out=%h", n, s_pc, s_out, e_pc, mem_word(e_pc));
                end
                n++;
            end
        end
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL wrap_timeout: got %0d instructions, want 2", n);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.fetch_en = 1'b1;
        bus.instr_ready = 1'b1;
        repeat (8) cyc();
        reset = 1'b1;
        cyc();
        checks++;
        if (s_rd !== 1'b0) begin
            errors++;
            $display("FAIL midreset_rd: got rd=%0b, want 0", s_rd);
        end
        reset = 1'b0;
        cyc();
        checks++;
        if ({s_valid, s_rd, s_addr, s_out, s_pc} !== 50'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got valid=%0b rd=%0b addr=%h out=%h pc=%h, want all zero",
                     s_valid, s_rd, s_addr, s_out, s_pc);
        end
        cyc();
        checks++;
        if ({s_valid, s_rd, s_addr} !== {1'b0, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL midreset_issue: got valid=%0b rd=%0b addr=%h, want 0 1 0000", s_valid, s_rd, s_addr);
        end
        cyc();
        checks++;
        if (s_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stale: got valid=%0b pc=%h out=%h, want valid 0", s_valid, s_pc, s_out);
        end
        cyc();
        checks++;
        if ({s_valid, s_pc, s_out} !== {1'b1, 16'h0000, 16'h1111}) begin
            errors++;
            $display("FAIL midreset_first: got valid=%0b pc=%h out=%h, want 1 0000 1111", s_valid, s_pc, s_out);
        end
    endtask

    task automatic test_idle();
        int n_rd;
        do_reset();
        bus.fetch_en = 1'b1;
        bus.instr_ready = 1'b0;
        cyc();
        cyc();
        checks++;
        if ({s_rd, s_addr} !== {1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL idle_first_issue: got rd=%0b addr=%h, want 1 0000", s_rd, s_addr);
        end
        bus.fetch_en = 1'b0;
        n_rd = 0;
        for (int k = 0; k < 7; k++) begin
            cyc();
            if (s_rd) n_rd++;
        end
        checks++;
        if (n_rd !== 0) begin
            errors++;
            $display("FAIL idle_no_issue: got %0d strobes, want 0", n_rd);
        end
        checks++;
        if ({s_valid, s_pc, s_out} !== {1'b1, 16'h0000, 16'h1111}) begin
            errors++;
            $display("FAIL idle_capture: got valid=%0b pc=%h out=%h, want 1 0000 1111", s_valid, s_pc, s_out);
        end
        bus.instr_ready = 1'b1;
        cyc();
        cyc();
        checks++;
        if ({s_valid, s_rd, s_out, s_pc} !== 34'd0) begin
            errors++;
            $display("FAIL idle_drained: got valid=%0b rd=%0b out=%h pc=%h, want all zero", s_valid, s_rd, s_out, s_pc);
        end
        bus.instr_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.fetch_en = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 16'h0000;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_mid();
        test_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1);
    end

endmodule
